// File: rtl/proc_test_pkg.sv
// Shared state encoding and default widths for the processor self-check sequencer.
package proc_test_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/proc_test_controller_compare.sv
// GPR sweep: index counter, comparator, first-fail latch and optional mismatch counter.
// PROC_TEST_MISMATCH_COUNT_EN selects full-sweep counting instead of stop-on-first-mismatch.
module proc_test_compare
  import proc_test_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FIRST_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              check_start,
  input  logic              check_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic [ADDR_W-1:0] idx,
  output logic              check_last,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [DATA_W-1:0] fail_actual,
  output logic [DATA_W-1:0] fail_expected
`ifdef PROC_TEST_MISMATCH_COUNT_EN
  ,
  output logic [ADDR_W:0]   mismatch_count
`endif
);
  logic [ADDR_W-1:0] idx_q, idx_d, fidx_q, fidx_d;
  logic [DATA_W-1:0] fact_q, fact_d, fexp_q, fexp_d;
  logic              pass_q, pass_d, seen_q, seen_d;
  logic              mismatch, at_end;

  assign mismatch = (rd_data != exp_data);
  assign at_end   = (idx_q == ADDR_W'(NUM_REGS - 1));

`ifdef PROC_TEST_MISMATCH_COUNT_EN
  logic [ADDR_W:0] cnt_q, cnt_d;
  assign check_last     = check_en && at_end;
  assign mismatch_count = cnt_q;
`else
  assign check_last = check_en && (mismatch || at_end);
`endif

  always_comb begin
    idx_d  = idx_q;
    fidx_d = fidx_q;
    fact_d = fact_q;
    fexp_d = fexp_q;
    pass_d = pass_q;
    seen_d = seen_q;
`ifdef PROC_TEST_MISMATCH_COUNT_EN
    cnt_d  = cnt_q;
`endif
    if (check_start) begin
      idx_d  = ADDR_W'(FIRST_REG);
      fidx_d = '0;
      fact_d = '0;
      fexp_d = '0;
      pass_d = 1'b0;
      seen_d = 1'b0;
`ifdef PROC_TEST_MISMATCH_COUNT_EN
      cnt_d  = '0;
`endif
    end else if (check_en) begin
      // Index parks on the last register examined so rd_addr points at it in DONE.
      if (!check_last) idx_d = idx_q + ADDR_W'(1);
      if (mismatch && !seen_q) begin
        fidx_d = idx_q;
        fact_d = rd_data;
        fexp_d = exp_data;
        seen_d = 1'b1;
      end
`ifdef PROC_TEST_MISMATCH_COUNT_EN
      if (mismatch && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      if (check_last) pass_d = (cnt_d == '0);
`else
      if (check_last) pass_d = !mismatch;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= ADDR_W'(FIRST_REG);
      fidx_q <= '0;
      fact_q <= '0;
      fexp_q <= '0;
      pass_q <= 1'b0;
      seen_q <= 1'b0;
`ifdef PROC_TEST_MISMATCH_COUNT_EN
      cnt_q  <= '0;
`endif
    end else begin
      idx_q  <= idx_d;
      fidx_q <= fidx_d;
      fact_q <= fact_d;
      fexp_q <= fexp_d;
      pass_q <= pass_d;
      seen_q <= seen_d;
`ifdef PROC_TEST_MISMATCH_COUNT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign idx           = idx_q;
  assign pass          = pass_q;
  assign fail_idx      = fidx_q;
  assign fail_actual   = fact_q;
  assign fail_expected = fexp_q;
endmodule

// File: rtl/proc_test_controller.sv
// Self-check sequencer: resets, runs and freezes the processor, then sweeps its GPRs.
// PROC_TEST_MISMATCH_COUNT_EN adds mismatch_count and forces a full sweep.
module proc_test_controller
  import proc_test_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int FIRST_REG    = 1,
  parameter int RESET_CYCLES = 2,
  parameter int CYC_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  output logic              proc_reset,
  output logic              proc_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [DATA_W-1:0] fail_actual,
  output logic [DATA_W-1:0] fail_expected,
  output logic [CYC_W-1:0]  cycle_count
`ifdef PROC_TEST_MISMATCH_COUNT_EN
  ,
  output logic [ADDR_W:0]   mismatch_count
`endif
);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]  run_len_q, run_len_d, cyc_q, cyc_d;
  logic              proc_reset_q, proc_reset_d, proc_en_q, proc_en_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              check_start, check_en, check_last;
  logic [ADDR_W-1:0] idx;

  assign check_en = (state_q == ST_CHECK);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    run_len_d   = run_len_q;
    cyc_d       = cyc_q;
    check_start = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          run_len_d   = run_cycles;
          cyc_d       = '0;
          rst_cnt_d   = RC_W'(RESET_CYCLES);
          check_start = 1'b1;
          state_d     = ST_RESET;
        end
      end
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q - RC_W'(1);
        if (rst_cnt_q == RC_W'(1)) state_d = (run_len_q == '0) ? ST_CHECK : ST_RUN;
      end
      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
        // run_len_q >= 1 here, so this marks the final RUN cycle.
        if (cyc_q == run_len_q - CYC_W'(1)) state_d = ST_CHECK;
      end
      ST_CHECK: if (check_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    proc_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    proc_en_d    = (state_d == ST_RESET) || (state_d == ST_RUN);
    busy_d       = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_CHECK);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      run_len_q    <= '0;
      cyc_q        <= '0;
      proc_reset_q <= 1'b1;
      proc_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      run_len_q    <= run_len_d;
      cyc_q        <= cyc_d;
      proc_reset_q <= proc_reset_d;
      proc_en_q    <= proc_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  proc_test_compare #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .FIRST_REG(FIRST_REG)
  ) u_cmp (
    .clk           (clk),
    .reset         (reset),
    .check_start   (check_start),
    .check_en      (check_en),
    .rd_data       (rd_data),
    .exp_data      (exp_data),
    .idx           (idx),
    .check_last    (check_last),
    .pass          (pass),
    .fail_idx      (fail_idx),
    .fail_actual   (fail_actual),
    .fail_expected (fail_expected)
`ifdef PROC_TEST_MISMATCH_COUNT_EN
    ,
    .mismatch_count(mismatch_count)
`endif
  );

  assign proc_reset  = proc_reset_q;
  assign proc_en     = proc_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cyc_q;
  assign rd_addr     = idx;
  assign exp_addr    = idx;
endmodule

// File: tb/tb_proc_test_controller.sv
// Randomized scoreboard bench for proc_test_controller with a register-file model.
module tb_proc_test_controller;
  localparam int DATA_W = 32, NUM_REGS = 32, ADDR_W = 5, FIRST_REG = 1;
  localparam int RESET_CYCLES = 2, CYC_W = 16;

  logic              clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [CYC_W-1:0]  run_cycles = '0;
  logic              proc_reset, proc_en, busy, done, pass;
  logic [ADDR_W-1:0] rd_addr, exp_addr, fail_idx;
  logic [DATA_W-1:0] rd_data, exp_data, fail_actual, fail_expected;
  logic [CYC_W-1:0]  cycle_count;
`ifdef PROC_TEST_MISMATCH_COUNT_EN
  logic [ADDR_W:0]   mismatch_count;
`endif

  logic [DATA_W-1:0] gpr  [NUM_REGS];
  logic [DATA_W-1:0] expm [NUM_REGS];
  assign rd_data  = gpr[rd_addr];
  assign exp_data = expm[exp_addr];

  always #5 clk = ~clk;

  proc_test_controller #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .FIRST_REG(FIRST_REG),
    .RESET_CYCLES(RESET_CYCLES), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .proc_reset(proc_reset), .proc_en(proc_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .exp_addr(exp_addr), .exp_data(exp_data), .busy(busy), .done(done), .pass(pass),
    .fail_idx(fail_idx), .fail_actual(fail_actual), .fail_expected(fail_expected),
    .cycle_count(cycle_count)
`ifdef PROC_TEST_MISMATCH_COUNT_EN
    , .mismatch_count(mismatch_count)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  typedef struct {
    bit          pass;
    int          fidx;
    logic [31:0] fact, fexp;
    int          cyc, chk_cycles, nmis;
  } exp_t;
  exp_t sb[$];

  // Reference: scan the register window for differences.
  function automatic exp_t model(int rc);
    exp_t e;
    int first = -1;
    e.nmis = 0;
    for (int r = FIRST_REG; r < NUM_REGS; r++)
      if (gpr[r] !== expm[r]) begin
        e.nmis++;
        if (first < 0) first = r;
      end
    e.pass = (e.nmis == 0);
    e.cyc  = rc;
    if (first < 0) begin e.fidx = 0; e.fact = 0; e.fexp = 0; end
    else begin e.fidx = first; e.fact = gpr[first]; e.fexp = expm[first]; end
`ifdef PROC_TEST_MISMATCH_COUNT_EN
    e.chk_cycles = NUM_REGS - FIRST_REG;
`else
    e.chk_cycles = (first < 0) ? NUM_REGS - FIRST_REG : first - FIRST_REG + 1;
`endif
    return e;
  endfunction

  // Monitor: phase-length counters per run, result check on each done rise.
  initial begin
    bit busy_prev = 0, done_prev = 0;
    int cr = 0, ce = 0, cc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_prev = 0; done_prev = 0;
      end else begin
        if (busy && !busy_prev) begin cr = 0; ce = 0; cc = 0; end
        if (busy) begin
          check("done_while_busy", done, 0);
          if (proc_reset) cr++;
          if (proc_en) ce++;
          if (!proc_reset && !proc_en) begin
            check("rd_addr_sweep", rd_addr, FIRST_REG + cc);
            check("exp_addr_eq", exp_addr, FIRST_REG + cc);
            cc++;
          end
        end
        if (done && !done_prev) begin
          if (sb.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            check("reset_cycles", cr, RESET_CYCLES);
            check("en_cycles", ce, RESET_CYCLES + e.cyc);
            check("check_cycles", cc, e.chk_cycles);
            check("cycle_count", cycle_count, e.cyc);
            check("pass", pass, e.pass);
            check("fail_idx", fail_idx, e.fidx);
            check("fail_actual", fail_actual, e.fact);
            check("fail_expected", fail_expected, e.fexp);
            check("done_busy_low", busy, 0);
            check("done_en_low", proc_en, 0);
            check("done_reset_low", proc_reset, 0);
`ifdef PROC_TEST_MISMATCH_COUNT_EN
            check("mismatch_count", mismatch_count, e.nmis);
`endif
          end
        end
        busy_prev = busy; done_prev = done;
      end
    end
  end

  task automatic fill(logic [31:0] v);
    for (int r = 0; r < NUM_REGS; r++) begin gpr[r] = v; expm[r] = v; end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < NUM_REGS; r++) begin gpr[r] = $urandom; expm[r] = gpr[r]; end
  endtask

  // Issue a start, then pulse start / wiggle run_cycles while busy to show they are ignored.
  task automatic run_one(int rc);
    exp_t e;
    bit seen = 0;
    e = model(rc);
    @(negedge clk);
    start = 1'b1; run_cycles = CYC_W'(rc);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; run_cycles = CYC_W'($urandom);
    check("start_done_low", done, 0);
    check("start_proc_reset", proc_reset, 1);
    check("start_busy", busy, 1);
    check("start_pass_clr", pass, 0);
    check("start_fail_idx_clr", fail_idx, 0);
    check("start_fail_act_clr", fail_actual, 0);
    check("start_cc_clr", cycle_count, 0);
    for (int i = 0; i < 400; i++) begin
      if (done) begin seen = 1; break; end
      start = ($urandom_range(0, 3) == 0);
      run_cycles = CYC_W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_timeout", seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fill(32'h0);
    repeat (3) @(negedge clk);
    check("rst_proc_reset", proc_reset, 1);
    check("rst_proc_en", proc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_idx", fail_idx, 0);
    check("rst_fail_actual", fail_actual, 0);
    check("rst_fail_expected", fail_expected, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_rd_addr", rd_addr, FIRST_REG);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    fill(32'hcafebabe);
    run_one(6);

    fill(32'h0);
    gpr[3] = 32'h5; expm[3] = 32'h8;
    run_one(4);

    fill_rand();
    gpr[2] = ~gpr[2]; gpr[31] = gpr[31] ^ 32'h10;
    run_one(3);

    fill(32'h12345678);
    gpr[0] = 32'hdeadbeef;
    run_one(0);

    // Abort in the middle of RUN.
    fill(32'h1);
    @(negedge clk); start = 1'b1; run_cycles = 16'd10;
    @(negedge clk); start = 1'b0;
    repeat (RESET_CYCLES + 3) @(negedge clk);
    check("abort_pre_cc", cycle_count, 3);
    check("abort_pre_en", proc_en, 1);
    reset = 1'b0;
    #1;
    check("abort_proc_reset", proc_reset, 1);
    check("abort_proc_en", proc_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cc", cycle_count, 0);
    check("abort_rd_addr", rd_addr, FIRST_REG);
    @(negedge clk); reset = 1'b1;

    for (int t = 0; t < 25; t++) begin
      int k;
      fill_rand();
      gpr[0] = $urandom;
      k = $urandom_range(0, 3);
      for (int m = 0; m < k; m++) begin
        int r = $urandom_range(FIRST_REG, NUM_REGS - 1);
        gpr[r] = gpr[r] ^ ($urandom | 32'h1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_one($urandom_range(0, 20));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
